// File: rtl/cpc_bus_initiator_pkg.sv
// Shared types and constants for the CPC expansion-bus initiator.
package cpc_bus_pkg;

    typedef enum logic [1:0] {
        CMD_MEMRD = 2'd0,
        CMD_MEMWR = 2'd1,
        CMD_IORD  = 2'd2,
        CMD_IOWR  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TWA,
        ST_TW,
        ST_T3,
        ST_RESP
    } state_e;

    localparam logic [1:0] ROM_LO = 2'b00;
    localparam logic [1:0] ROM_HI = 2'b11;

    function automatic logic cmd_is_io(cmd_e t);
        return (t == CMD_IORD) || (t == CMD_IOWR);
    endfunction

    function automatic logic cmd_is_write(cmd_e t);
        return (t == CMD_MEMWR) || (t == CMD_IOWR);
    endfunction

endpackage

// File: rtl/cpc_bus_initiator_if.sv
// Command/response handshake plus the edge-connector pins of the initiator.
interface cpc_bus_initiator_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic        cmd_m1;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        lower_rom_en;
    logic        upper_rom_en;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_romdis;
    logic        rsp_timeout;
    logic [15:0] A;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in;
    logic        MREQ_B;
    logic        IOREQ_B;
    logic        RD_B;
    logic        WR_B;
    logic        M1_B;
    logic        ROMEN_B;
    logic        RFSH_B;
    logic        READY;
    logic        ROMDIS;

    modport master (
        input  cmd_valid, cmd_type, cmd_m1, cmd_addr, cmd_wdata,
        input  lower_rom_en, upper_rom_en, D_in, READY, ROMDIS,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_romdis, rsp_timeout,
        output A, D_out, D_oe, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, ROMEN_B, RFSH_B
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_m1, cmd_addr, cmd_wdata,
        output lower_rom_en, upper_rom_en, D_in, READY, ROMDIS,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_romdis, rsp_timeout,
        input  A, D_out, D_oe, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, ROMEN_B, RFSH_B
    );

endinterface

// File: rtl/cpc_bus_initiator_rom_region_decode.sv
// ROMEN qualifier: a memory read into an enabled lower or upper ROM window.
module cpc_rom_region_decode
    import cpc_bus_pkg::*;
(
    input  logic [1:0] region,
    input  logic       lower_en,
    input  logic       upper_en,
    input  logic       is_memrd,
    output logic       rom_sel
);

    always_comb begin
        rom_sel = is_memrd &&
                  (((region == ROM_LO) && lower_en) || ((region == ROM_HI) && upper_en));
    end

endmodule

// File: rtl/cpc_bus_initiator.sv
// Z80-style memory/I/O cycle generator for the Amstrad CPC expansion bus.
module cpc_bus_initiator
    import cpc_bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT     = 16,
    parameter int unsigned IO_AUTO_WAIT = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    cpc_bus_initiator_if.master  bus
);

    state_e      state, state_nxt;
    cmd_e        cmd_q;
    logic        m1_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        lo_q, hi_q;
    logic [7:0]  wait_cnt;
    logic [1:0]  aw_cnt;
    logic [7:0]  rdata_q;
    logic        romdis_q;
    logic        timeout_q;

    logic        accept, is_io, is_wr, is_memrd;
    logic        aw_last, wait_last, abort;
    logic        in_req, rom_sel;

    assign is_io    = cmd_is_io(cmd_q);
    assign is_wr    = cmd_is_write(cmd_q);
    assign is_memrd = (cmd_q == CMD_MEMRD);
    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign aw_last  = (({1'b0, aw_cnt} + 3'd1) == 3'(IO_AUTO_WAIT));
    assign wait_last = (({1'b0, wait_cnt} + 9'd1) == 9'(MAX_WAIT));

    cpc_rom_region_decode u_rom_decode (
        .region   (addr_q[15:14]),
        .lower_en (lo_q),
        .upper_en (hi_q),
        .is_memrd (is_memrd),
        .rom_sel  (rom_sel)
    );

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state     <= ST_IDLE;
            cmd_q     <= CMD_MEMRD;
            m1_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lo_q      <= 1'b0;
            hi_q      <= 1'b0;
            wait_cnt  <= '0;
            aw_cnt    <= '0;
            rdata_q   <= '0;
            romdis_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_q   <= cmd_e'(bus.cmd_type);
                m1_q    <= bus.cmd_m1;
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
                lo_q    <= bus.lower_rom_en;
                hi_q    <= bus.upper_rom_en;
            end
            if (state == ST_TW)
                wait_cnt <= wait_cnt + 8'd1;
            else if (state == ST_IDLE)
                wait_cnt <= '0;
            if (state == ST_T2)
                aw_cnt <= '0;
            else if (state == ST_TWA)
                aw_cnt <= aw_cnt + 2'd1;
            // Response registers change only on entry to RESP, so they hold in between.
            if (state == ST_T3) begin
                rdata_q   <= is_wr ? 8'h00 : bus.D_in;
                romdis_q  <= is_memrd && bus.ROMDIS;
                timeout_q <= 1'b0;
            end else if (abort) begin
                rdata_q   <= '0;
                romdis_q  <= 1'b0;
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        unique case (state)
            ST_IDLE: if (accept) state_nxt = ST_T1;
            ST_T1:   state_nxt = ST_T2;
            ST_T2: begin
                if (is_io && (IO_AUTO_WAIT != 0))
                    state_nxt = ST_TWA;
                else
                    state_nxt = bus.READY ? ST_T3 : ST_TW;
            end
            ST_TWA: begin
                if (aw_last)
                    state_nxt = bus.READY ? ST_T3 : ST_TW;
            end
            ST_TW: begin
                if (bus.READY) begin
                    state_nxt = ST_T3;
                end else if (wait_last) begin
                    state_nxt = ST_RESP;
                    abort     = 1'b1;
                end
            end
            ST_T3:   state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_req = (state == ST_T2) || (state == ST_TWA) || (state == ST_TW) || (state == ST_T3);

        bus.cmd_ready   = (state == ST_IDLE) && RESET_B;
        bus.rsp_valid   = (state == ST_RESP);
        bus.rsp_rdata   = rdata_q;
        bus.rsp_romdis  = romdis_q;
        bus.rsp_timeout = timeout_q;
        bus.A           = addr_q;
        bus.D_out       = wdata_q;
        bus.D_oe        = is_wr && (in_req || (state == ST_T1));
        bus.MREQ_B      = !(in_req && !is_io);
        bus.IOREQ_B     = !(in_req && is_io);
        bus.RD_B        = !(in_req && !is_wr);
        bus.WR_B        = !(in_req && is_wr);
        bus.M1_B        = !(((state == ST_T1) || (state == ST_T2)) && is_memrd && m1_q);
        bus.ROMEN_B     = !(rom_sel &&
                            ((state == ST_T2) || (state == ST_TW) || (state == ST_T3)));
        bus.RFSH_B      = 1'b1;
    end

endmodule

// File: tb/tb_cpc_bus_initiator.sv
// Directed plus randomized cycles on cpc_bus_initiator, checked against a cycle-count model.
module tb_cpc_bus_initiator;
    import cpc_bus_pkg::*;

    localparam int unsigned MW = 16;
    localparam int unsigned AW = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cpc_bus_initiator_if bif();

    cpc_bus_initiator #(.MAX_WAIT(MW), .IO_AUTO_WAIT(AW)) dut (
        .CLK     (clk),
        .RESET_B (rst_n),
        .bus     (bif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command: expectations come from the cycle rules, READY is driven by edge count.
    task automatic run_cmd(input logic [1:0] t, input logic m1, input logic [15:0] addr,
                           input logic [7:0] wd, input logic lo, input logic hi,
                           input int w, input logic [7:0] din, input logic rdis);
        bit   is_io  = (t >= 2'd2);
        bit   is_wr  = (t == 2'd1) || (t == 2'd3);
        bit   is_mrd = (t == 2'd0);
        int   iow    = is_io ? int'(AW) : 0;
        bit   to     = (w > int'(MW));
        int   lat_e  = to ? 2 + iow + int'(MW) : 3 + iow + w;
        int   act    = to ? 1 + iow + int'(MW) : 2 + iow + w;
        bit   rom    = is_mrd && ((addr < 16'h4000 && lo) || (addr >= 16'hC000 && hi));
        int   first  = 2 + iow;
        logic [7:0] rd_e = (to || is_wr) ? 8'h00 : din;
        bit   rdis_e = !to && is_mrd && rdis;
        int   k = 0, lat = -1;
        bit   got = 0;
        int   n_mreq = 0, n_ioreq = 0, n_rd = 0, n_wr = 0, n_m1 = 0, n_rom = 0, n_oe = 0;
        int   a_bad = 0, d_bad = 0, rdy_bad = 0;

        @(negedge clk);
        chk("ready_idle", bif.cmd_ready, 1);
        bif.cmd_type = t; bif.cmd_m1 = m1; bif.cmd_addr = addr; bif.cmd_wdata = wd;
        bif.lower_rom_en = lo; bif.upper_rom_en = hi;
        bif.D_in = din; bif.ROMDIS = rdis; bif.READY = 1'b1; bif.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0;
        bif.lower_rom_en = 1'($urandom); bif.upper_rom_en = 1'($urandom);
        bif.cmd_addr = 16'($urandom); bif.cmd_wdata = 8'($urandom);
        while (!got && k < 80) begin
            bif.READY = !((k + 1) >= first && (k + 1) < first + w);
            @(negedge clk);
            if (bif.rsp_valid) begin
                got = 1; lat = k;
                chk("resp_strobes", {bif.MREQ_B, bif.IOREQ_B, bif.RD_B, bif.WR_B,
                                     bif.M1_B, bif.ROMEN_B, bif.D_oe}, 7'b1111110);
                chk("rsp_rdata", bif.rsp_rdata, rd_e);
                chk("rsp_romdis", bif.rsp_romdis, rdis_e);
                chk("rsp_timeout", bif.rsp_timeout, to);
            end else begin
                n_mreq  += int'(!bif.MREQ_B);
                n_ioreq += int'(!bif.IOREQ_B);
                n_rd    += int'(!bif.RD_B);
                n_wr    += int'(!bif.WR_B);
                n_m1    += int'(!bif.M1_B);
                n_rom   += int'(!bif.ROMEN_B);
                n_oe    += int'(bif.D_oe);
                if ((!bif.MREQ_B || !bif.IOREQ_B || !bif.M1_B) && bif.A !== addr) a_bad++;
                if (bif.D_oe && bif.D_out !== wd) d_bad++;
                if (bif.cmd_ready) rdy_bad++;
            end
            @(posedge clk); #1;
            k++;
        end
        bif.READY = 1'b1;
        chk("rsp_seen", got, 1);
        chk("latency", lat, lat_e);
        chk("mreq_cycles", n_mreq, is_io ? 0 : act);
        chk("ioreq_cycles", n_ioreq, is_io ? act : 0);
        chk("rd_cycles", n_rd, is_wr ? 0 : act);
        chk("wr_cycles", n_wr, is_wr ? act : 0);
        chk("m1_cycles", n_m1, (is_mrd && m1) ? 2 : 0);
        chk("romen_cycles", n_rom, rom ? act : 0);
        chk("doe_cycles", n_oe, is_wr ? act + 1 : 0);
        chk("addr_hold", a_bad, 0);
        chk("dout_hold", d_bad, 0);
        chk("busy_not_ready", rdy_bad, 0);
        @(negedge clk);
        chk("rsp_pulse_one", bif.rsp_valid, 0);
        chk("rsp_rdata_hold", bif.rsp_rdata, rd_e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0]  t;
        logic [15:0] a;
        int          r, w;

        bif.cmd_valid = 1'b0; bif.cmd_type = 2'd0; bif.cmd_m1 = 1'b0;
        bif.cmd_addr = '0; bif.cmd_wdata = '0; bif.lower_rom_en = 1'b0;
        bif.upper_rom_en = 1'b0; bif.D_in = '0; bif.READY = 1'b1; bif.ROMDIS = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_strobes", {bif.MREQ_B, bif.IOREQ_B, bif.RD_B, bif.WR_B,
                            bif.M1_B, bif.ROMEN_B, bif.RFSH_B}, 7'h7F);
        chk("rst_doe", bif.D_oe, 0);
        chk("rst_addr", bif.A, 0);
        chk("rst_dout", bif.D_out, 0);
        chk("rst_rsp", {bif.rsp_valid, bif.rsp_rdata, bif.rsp_romdis, bif.rsp_timeout}, 0);
        chk("rst_cmd_ready", bif.cmd_ready, 0);
        rst_n = 1'b1;

        run_cmd(2'd0, 1'b0, 16'hC000, 8'h00, 1'b0, 1'b1, 0, 8'hA5, 1'b1);
        run_cmd(2'd1, 1'b0, 16'h4000, 8'h3C, 1'b1, 1'b1, 2, 8'h00, 1'b1);
        run_cmd(2'd3, 1'b0, 16'hDF07, 8'h55, 1'b1, 1'b1, 0, 8'h77, 1'b0);
        run_cmd(2'd0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 0, 8'h5A, 1'b0);
        run_cmd(2'd0, 1'b0, 16'h0100, 8'h00, 1'b1, 1'b0, 0, 8'h11, 1'b1);
        run_cmd(2'd0, 1'b0, 16'hC123, 8'h00, 1'b1, 1'b1, int'(MW) + 5, 8'hEE, 1'b1);
        run_cmd(2'd0, 1'b0, 16'hC124, 8'h00, 1'b1, 1'b1, int'(MW), 8'h42, 1'b1);
        run_cmd(2'd2, 1'b1, 16'hBC00, 8'h00, 1'b1, 1'b1, 3, 8'h99, 1'b1);

        for (int i = 0; i < 30; i++) begin
            t = 2'($urandom_range(0, 3));
            a = {2'($urandom_range(0, 3)), 14'($urandom)};
            r = int'($urandom_range(0, 9));
            w = (r < 7) ? r % 4 : ((r == 7) ? int'(MW) : int'(MW) + 1 + int'($urandom_range(0, 3)));
            run_cmd(t, 1'($urandom), a, 8'($urandom), 1'($urandom), 1'($urandom),
                    w, 8'($urandom), 1'($urandom));
        end

        // Reset in the middle of a wait-stated read, then a write.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bif.cmd_type = (i == 0) ? 2'd0 : 2'd1;
            bif.cmd_addr = 16'hC234; bif.cmd_wdata = 8'h99; bif.cmd_m1 = 1'b0;
            bif.lower_rom_en = 1'b1; bif.upper_rom_en = 1'b1;
            bif.READY = 1'b0; bif.cmd_valid = 1'b1;
            @(posedge clk); #1;
            bif.cmd_valid = 1'b0;
            repeat (4) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            chk("midrst_strobes", {bif.MREQ_B, bif.IOREQ_B, bif.RD_B, bif.WR_B,
                                   bif.M1_B, bif.ROMEN_B}, 6'h3F);
            chk("midrst_doe", bif.D_oe, 0);
            chk("midrst_ready", bif.cmd_ready, 0);
            chk("midrst_rsp", bif.rsp_valid, 0);
            @(negedge clk);
            rst_n = 1'b1; bif.READY = 1'b1;
            #1;
            chk("release_ready", bif.cmd_ready, 1);
            n = 0;
            repeat (6) begin
                @(negedge clk);
                if (bif.rsp_valid) n++;
            end
            chk("midrst_no_rsp", n, 0);
        end

        run_cmd(2'd0, 1'b1, 16'h3FFF, 8'h00, 1'b1, 1'b0, 1, 8'hC3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpc_bus_initiator.md
Name: cpc_bus_initiator

Overview:
- Synthesisable Amstrad CPC expansion-bus master. It generates Z80-style memory and I/O cycles on the 50-way edge-connector signals.
- It is the initiator for ROM/RAM expansion boards that respond to ROMEN_B/A14 and drive data or assert ROMDIS. Typical targets are the Teensy ROM board and RAM boards.
- It sits between a simple command/response interface, fed by a bench sequencer or an FPGA host, and the bus pins.
- One CLK period is one T-state.

Parameters:
- MAX_WAIT, 16, maximum consecutive TW states allowed before a cycle is aborted; range 1..255.
- IO_AUTO_WAIT, 1, number of forced wait states inserted in I/O cycles; range 0..3.

Ports:
- CLK  in  1  bus clock; one T-state per period
- RESET_B  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high at a CLK edge
- cmd_type  in  2  0=MEMRD, 1=MEMWR, 2=IORD, 3=IOWR
- cmd_m1  in  1  opcode fetch; honoured only for MEMRD
- cmd_addr  in  16  cycle address
- cmd_wdata  in  8  write data
- lower_rom_en  in  1  ROMEN_B enabled for address &0000-&3FFF
- upper_rom_en  in  1  ROMEN_B enabled for address &C000-&FFFF
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  8  captured read data; 0 for writes
- rsp_romdis  out  1  ROMDIS sampled during a read
- rsp_timeout  out  1  cycle aborted by the wait watchdog
- A  out  16  address bus
- D_out  out  8  data bus output
- D_oe  out  1  data bus output enable
- D_in  in  8  data bus input
- MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, ROMEN_B  out  1 each  bus strobes, active low
- RFSH_B  out  1  tied high
- READY  in  1  wait request; low inserts TW states
- ROMDIS  in  1  ROM disable from the expansion board

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All strobes go high; D_oe=0; A=0; D_out=0; rsp_* =0; state=IDLE.
  - While RESET_B is low, cmd_ready=0.
  - Reset mid-cycle abandons the cycle with no response.
- States: IDLE, T1, T2, TWA, TW, T3, RESP.
- Transitions:
  - IDLE -> T1 on command accept. The command is registered; A=cmd_addr from T1 onward, held until IDLE.
  - T1 -> T2.
  - T2 -> TWA for I/O cycles when IO_AUTO_WAIT>0. TWA repeats IO_AUTO_WAIT times and ignores READY.
  - After T2, or after the last TWA: READY=1 -> T3; READY=0 -> TW.
  - TW: wait counter increments. READY=1 -> T3. Otherwise, when the counter reaches MAX_WAIT -> RESP with timeout.
  - T3 -> RESP.
  - RESP -> IDLE. rsp_valid=1 for exactly this cycle.
- Strobe timing:
  - MREQ_B (memory) or IOREQ_B (I/O) is low in T2/TWA/TW/T3.
  - RD_B (reads) or WR_B (writes) is low in T2/TWA/TW/T3.
  - M1_B is low in T1 and T2 for MEMRD with cmd_m1=1.
  - ROMEN_B is low in T2/TW/T3 for MEMRD when (A[15:14]=00 and lower_rom_en) or (A[15:14]=11 and upper_rom_en).
  - ROMEN_B is never asserted for writes or I/O.
- Writes: D_out=cmd_wdata with D_oe=1 from T1 through T3. D_oe=0 in all other states.
- Reads:
  - D_in and ROMDIS are captured on the edge leaving T3 into rsp_rdata and rsp_romdis.
  - rsp_romdis=0 for writes and I/O.
- Timeout:
  - On abort, strobes deassert on entry to RESP.
  - rsp_timeout=1, rsp_rdata=0.
  - The wait counter clears in IDLE.
- Response hold: rsp_rdata, rsp_romdis and rsp_timeout hold their values until the next RESP.
- Latency, accept edge to rsp_valid high:
  - Memory cycle, no waits: 3 edges.
  - I/O cycle: 3+IO_AUTO_WAIT edges.
  - Each TW adds 1 edge.
- Back-to-back: minimum command spacing is 5 cycles for memory; the next accept happens in the IDLE cycle after RESP.
- Configuration sampling: lower_rom_en and upper_rom_en are sampled at accept; changes mid-cycle are ignored.

Decomposition:
- Package cpc_bus_pkg:
  - cmd_type encodings CMD_MEMRD/MEMWR/IORD/IOWR.
  - State enum.
  - ROM region constants ROM_LO=2'b00, ROM_HI=2'b11.
- Sub-module cpc_rom_region_decode: combinational ROMEN qualifier from A[15:14], the registered enables and the read type. The FSM, wait counter and capture registers stay in the top module.

Test Plan:
- MEMRD &C000 with upper_rom_en=1, READY=1, D_in=&A5, ROMDIS=1 -> ROMEN_B, MREQ_B and RD_B low for 2 cycles; rsp_valid 3 edges after accept; rsp_rdata=&A5; rsp_romdis=1.
- MEMWR &4000 data &3C with READY low for 2 cycles after T2 -> 2 TW states; WR_B low for 4 cycles; D_oe high for 5 cycles; ROMEN_B stays high; rsp_valid 5 edges after accept.
- IOWR &DF07 with IO_AUTO_WAIT=1 -> IOREQ_B and WR_B low for 3 cycles; MREQ_B stays high; rsp_valid 4 edges after accept.
- MEMRD &0000 with lower_rom_en=0 and cmd_m1=1 -> ROMEN_B stays high; M1_B low in T1 and T2; data captured normally.
- READY held low with MAX_WAIT=16 -> exactly 16 TW cycles; rsp_timeout=1; rsp_rdata=0; strobes high in RESP.
- RESET_B asserted during TW of a read -> all strobes high and D_oe=0 in the same cycle; no rsp_valid; cmd_ready=1 in the first cycle after release.
